// File: rtl/decade_pkg.sv
// Shared types, constants and digit helpers for the cascaded BCD decade sequencer.
// Imported by the interface, the digit cell and the sequencer top.
package decade_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // One BCD step; the caller decides whether the step is allowed.
  function automatic logic [DIGIT_W-1:0] bcd_step(input logic [DIGIT_W-1:0] q,
                                                  input logic up);
    if (up) begin
      return (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
    end
    return (q == 4'd0) ? BCD_MAX : q - 4'd1;
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/decade_seq_ctrl_if.sv
// Control/status bundle between the register block (master) and the sequencer (slave).
// The BCD count and status flags flow back to the master side.
interface decade_seq_ctrl_if
  import decade_pkg::*;
#(
  parameter int NDIGITS = 2
) ();

  logic                       start;
  logic                       abort;
  logic                       pause;
  logic                       tick;
  logic                       count_up;
  logic                       auto_reload;
  logic [DIGIT_W*NDIGITS-1:0] preset;
  logic [DIGIT_W*NDIGITS-1:0] count;
  logic                       busy;
  logic                       done;
  logic                       done_pulse;
  logic [2:0]                 state;

  modport master (
    output start, abort, pause, tick, count_up, auto_reload, preset,
    input  count, busy, done, done_pulse, state
  );

  modport slave (
    input  start, abort, pause, tick, count_up, auto_reload, preset,
    output count, busy, done, done_pulse, state
  );

endinterface

// File: rtl/decade_seq_ctrl_bcd_digit.sv
// Single BCD digit with synchronous load/step and asynchronous clear.
// carry_out_o flags the digit sitting at its roll-over value for the current direction.
module bcd_digit
  import decade_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               en_i,
  input  logic               up_i,
  output logic [DIGIT_W-1:0] q_o,
  output logic               carry_out_o
);

  logic [DIGIT_W-1:0] q_q;

  // Load outranks stepping so an abort or reload always lands cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (en_i) begin
      q_q <= bcd_step(q_q, up_i);
    end
  end

  assign q_o         = q_q;
  assign carry_out_o = up_i ? (q_q == BCD_MAX) : (q_q == 4'd0);

endmodule

// File: rtl/decade_seq_ctrl.sv
// Programmable BCD event timer/counter: loads a preset, counts qualified ticks up or down
// to a terminal value, with pause, abort and optional auto-reload.
module decade_seq_ctrl
  import decade_pkg::*;
#(
  parameter int NDIGITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  decade_seq_ctrl_if.slave  bus
);

  localparam int W = DIGIT_W * NDIGITS;

  state_e         state_q, state_d;
  logic [W-1:0]   target_q, target_d;
  logic           up_q, up_d;
  logic           busy_q, done_q, pulse_q, pulse_d;

  logic [W-1:0]   preset_clamped;
  logic [W-1:0]   count;
  logic [W-1:0]   count_stepped;
  logic [W-1:0]   terminal;
  logic [W-1:0]   load_val;
  logic           load_digits;
  logic           chain_sat;
  logic           step;
  logic           run_hit;
  logic           load_hit;

  // ripple marks digits that change if a step happens; count_stepped is the value
  // after that step, letting the terminal be seen on the same edge it is reached.
  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    logic ripple;
    logic carry;
    logic en;

    if (k == 0) begin : g_lsb
      assign ripple = 1'b1;
    end else begin : g_upper
      assign ripple = g_digit[k-1].ripple & g_digit[k-1].carry;
    end

    assign en = step & ripple;
    assign preset_clamped[k*DIGIT_W +: DIGIT_W] = bcd_clamp(bus.preset[k*DIGIT_W +: DIGIT_W]);
    assign count_stepped[k*DIGIT_W +: DIGIT_W]  =
      ripple ? bcd_step(count[k*DIGIT_W +: DIGIT_W], up_q) : count[k*DIGIT_W +: DIGIT_W];

    bcd_digit u_digit (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_digits),
      .load_val_i  (load_val[k*DIGIT_W +: DIGIT_W]),
      .en_i        (en),
      .up_i        (up_q),
      .q_o         (count[k*DIGIT_W +: DIGIT_W]),
      .carry_out_o (carry)
    );
  end

  // Whole chain at its roll-over point: stepping would wrap, so it is never allowed.
  assign chain_sat = g_digit[NDIGITS-1].ripple & g_digit[NDIGITS-1].carry;

  assign terminal    = up_q ? target_q : '0;
  assign load_hit    = (target_q == '0);
  assign step        = (state_q == ST_RUN) && bus.tick && !bus.pause && !bus.abort && !chain_sat;
  assign run_hit     = step && (count_stepped == terminal);
  assign load_digits = bus.abort || (state_q == ST_LOAD);
  assign load_val    = (bus.abort || up_q) ? '0 : target_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    up_d     = up_q;
    pulse_d  = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            target_d = preset_clamped;
            up_d     = bus.count_up;
            state_d  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_hit) begin
            pulse_d = 1'b1;
            state_d = bus.auto_reload ? ST_LOAD : ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (run_hit) begin
            pulse_d = 1'b1;
            state_d = bus.auto_reload ? ST_LOAD : ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags are derived from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      up_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      up_q     <= up_d;
      busy_q   <= state_d inside {ST_LOAD, ST_RUN, ST_PAUSE};
      done_q   <= (state_d == ST_DONE);
      pulse_q  <= pulse_d;
    end
  end

  assign bus.count      = count;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = pulse_q;
  assign bus.state      = state_q;

endmodule
